sprite_line_writer: RTL and testbench

- Write-side engine for the sprite line buffers (the 1024x9 line buffer, or the generic line buffer with clear-on-read).
- Accepts one 16-pixel, 2bpp sprite row descriptor per handshake.
- Serialises the row into one write slot per clock on the buffer's write port, skipping transparent pixels.
- The scan-out side reads and clears the buffer independently; this block only ever drives the write port.

---
 rtl/sprite_line_writer_if.sv | 27 ++
 rtl/sprite_line_writer.sv | 110 +++++++++++
 tb/tb_sprite_line_writer.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/sprite_line_writer_if.sv
// Descriptor handshake and line-buffer write port of the sprite line writer.
interface sprite_line_writer_if #(
    parameter int AW = 10,
    parameter int CW = 7
);
    logic          req;
    logic          rdy;
    logic [AW-1:0] x;
    logic          flip;
    logic [CW-1:0] col;
    logic [31:0]   pix;
    logic          abort;
    logic [AW-1:0] wad;
    logic          we;
    logic [CW+1:0] wdt;
    logic          done;

    modport master (
        output req, x, flip, col, pix, abort,
        input  rdy, wad, we, wdt, done
    );

    modport slave (
        input  req, x, flip, col, pix, abort,
        output rdy, wad, we, wdt, done
    );
endinterface

// File: rtl/sprite_line_writer.sv
// Serialises one 16-pixel 2bpp sprite row into 16 write slots on the line
// buffer write port, one slot per clock, suppressing transparent pixels.
module sprite_line_writer #(
    parameter int AW = 10,
    parameter int CW = 7
) (
    input logic                  cl,
    input logic                  rst_n,
    sprite_line_writer_if.slave  bus
);
    localparam int DW = CW + 2;

    typedef enum logic {IDLE, DRAW} state_t;

    state_t        state, stateNext;
    logic [3:0]    cnt, cntNext;
    logic [AW-1:0] xLat, xLatNext;
    logic          flipLat, flipLatNext;
    logic [CW-1:0] colLat, colLatNext;
    logic [31:0]   pixLat, pixLatNext;
    logic [AW-1:0] wadQ, wadNext;
    logic          weQ, weNext;
    logic [DW-1:0] wdtQ, wdtNext;
    logic          doneQ, doneNext;

    logic          rdy;
    logic          accept;
    logic [3:0]    pIdx;
    logic [1:0]    pixel;

    // Ready while idle, or on the last slot so back-to-back rows leave no bubble.
    assign rdy    = (state == IDLE) || (state == DRAW && cnt == 4'd15);
    assign accept = bus.req && rdy && !bus.abort;

    // Pick the source pixel for the current slot; flipping just reverses the index.
    always_comb begin
        pIdx  = flipLat ? ~cnt : cnt;
        pixel = pixLat[{pIdx, 1'b0} +: 2];
    end

    // Next-state and next-output logic; abort overrides both drawing and accepting.
    always_comb begin
        stateNext   = state;
        cntNext     = cnt;
        xLatNext    = xLat;
        flipLatNext = flipLat;
        colLatNext  = colLat;
        pixLatNext  = pixLat;
        wadNext     = wadQ;
        weNext      = 1'b0;
        wdtNext     = wdtQ;
        doneNext    = 1'b0;

        if (bus.abort) begin
            stateNext = IDLE;
        end else begin
            if (state == DRAW) begin
                wadNext = xLat + AW'(cnt);
                weNext  = (pixel != 2'd0);
                wdtNext = {colLat, pixel};
                cntNext = cnt + 4'd1;
                if (cnt == 4'd15) begin
                    doneNext  = 1'b1;
                    stateNext = IDLE;
                end
            end
            if (accept) begin
                xLatNext    = bus.x;
                flipLatNext = bus.flip;
                colLatNext  = bus.col;
                pixLatNext  = bus.pix;
                stateNext   = DRAW;
                cntNext     = 4'd0;
            end
        end
    end

    // State, latched descriptor and registered write-port outputs.
    always_ff @(posedge cl) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            xLat    <= '0;
            flipLat <= 1'b0;
            colLat  <= '0;
            pixLat  <= '0;
            wadQ    <= '0;
            weQ     <= 1'b0;
            wdtQ    <= '0;
            doneQ   <= 1'b0;
        end else begin
            state   <= stateNext;
            cnt     <= cntNext;
            xLat    <= xLatNext;
            flipLat <= flipLatNext;
            colLat  <= colLatNext;
            pixLat  <= pixLatNext;
            wadQ    <= wadNext;
            weQ     <= weNext;
            wdtQ    <= wdtNext;
            doneQ   <= doneNext;
        end
    end

    assign bus.rdy  = rdy;
    assign bus.wad  = wadQ;
    assign bus.we   = weQ;
    assign bus.wdt  = wdtQ;
    assign bus.done = doneQ;
endmodule

// File: tb/tb_sprite_line_writer.sv
// Directed bench for sprite_line_writer with a cycle-stamped slot scoreboard.
module tb_sprite_line_writer;
    logic cl;
    logic rst_n;
    int   cyc;
    int   checks;
    int   failures;
    int   readyCyc;
    int   writeCount;
    int   doneCount;
    logic monOn;

    typedef struct {
        int         cyc;
        logic       we;
        logic [9:0] wad;
        logic [8:0] wdt;
        logic       done;
    } slot_t;

    slot_t sb[$];

    sprite_line_writer_if #(.AW(10), .CW(7)) bus ();

    sprite_line_writer #(.AW(10), .CW(7)) dut (
        .cl    (cl),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Free-running clock.
    initial begin
        cl = 1'b0;
        forever #5 cl = ~cl;
    end

    // Cycle stamp used to line scoreboard entries up with output cycles.
    always @(posedge cl) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    // Drop expected slots at or after the given cycle (abort/reset cancels them).
    task automatic purgeFrom(input int lim);
        while (sb.size() > 0 && sb[sb.size()-1].cyc >= lim) void'(sb.pop_back());
    endtask

    // Present a descriptor from a negedge and hold it until the model says it is taken.
    task automatic applyStimulus(input logic [9:0] ax, input logic af, input logic [6:0] ac, input logic [31:0] ap);
        slot_t e;
        int    p;
        logic  expRdy;
        bus.req  = 1'b1;
        bus.x    = ax;
        bus.flip = af;
        bus.col  = ac;
        bus.pix  = ap;
        for (int k = 0; k < 40; k++) begin
            expRdy = (cyc >= readyCyc);
            checkOutput("rdy", {31'd0, bus.rdy}, {31'd0, expRdy});
            if (expRdy) begin
                @(posedge cl);
                #1;
                for (int i = 0; i < 16; i++) begin
                    p      = af ? 15 - i : i;
                    e.cyc  = cyc + 1 + i;
                    e.wad  = ax + 10'(i);
                    e.wdt  = {ac, ap[2*p +: 2]};
                    e.we   = (ap[2*p +: 2] != 2'd0);
                    e.done = (i == 15);
                    sb.push_back(e);
                end
                readyCyc = cyc + 15;
                @(negedge cl);
                return;
            end
            @(negedge cl);
        end
        checkOutput("acceptTimeout", 32'd0, 32'd1);
    endtask

    // Compare every output cycle against the scoreboard head or against idle.
    always @(negedge cl) begin
        if (monOn) begin
            if (bus.we === 1'b1) writeCount++;
            if (bus.done === 1'b1) doneCount++;
            while (sb.size() > 0 && sb[0].cyc < cyc) begin
                checkOutput("slotMissed", 32'(sb[0].cyc), 32'(cyc));
                void'(sb.pop_front());
            end
            if (sb.size() > 0 && sb[0].cyc == cyc) begin
                slot_t e;
                e = sb.pop_front();
                checkOutput("we",   {31'd0, bus.we},   {31'd0, e.we});
                checkOutput("wad",  {22'd0, bus.wad},  {22'd0, e.wad});
                checkOutput("wdt",  {23'd0, bus.wdt},  {23'd0, e.wdt});
                checkOutput("done", {31'd0, bus.done}, {31'd0, e.done});
            end else begin
                checkOutput("idleWe",   {31'd0, bus.we},   32'd0);
                checkOutput("idleDone", {31'd0, bus.done}, 32'd0);
            end
        end
    end

    int w0;
    int d0;

    initial begin
        cyc        = 0;
        checks     = 0;
        failures   = 0;
        readyCyc   = 0;
        writeCount = 0;
        doneCount  = 0;
        monOn      = 1'b0;
        rst_n      = 1'b0;
        bus.req    = 1'b0;
        bus.x      = '0;
        bus.flip   = 1'b0;
        bus.col    = '0;
        bus.pix    = '0;
        bus.abort  = 1'b0;

        repeat (3) @(posedge cl);
        @(negedge cl);
        checkOutput("rstWe",   {31'd0, bus.we},   32'd0);
        checkOutput("rstWad",  {22'd0, bus.wad},  32'd0);
        checkOutput("rstWdt",  {23'd0, bus.wdt},  32'd0);
        checkOutput("rstDone", {31'd0, bus.done}, 32'd0);
        checkOutput("rstRdy",  {31'd0, bus.rdy},  32'd1);
        rst_n = 1'b1;
        monOn = 1'b1;

        $display("[TB] basic row");
        applyStimulus(10'h100, 1'b0, 7'h05, 32'hAAAAAAAA);
        bus.req = 1'b0;
        repeat (20) @(negedge cl);

        $display("[TB] transparency, no flip");
        applyStimulus(10'h040, 1'b0, 7'h00, 32'h0000000F);
        bus.req = 1'b0;
        repeat (20) @(negedge cl);

        $display("[TB] transparency, flip");
        applyStimulus(10'h040, 1'b1, 7'h00, 32'h0000000F);
        bus.req = 1'b0;
        repeat (20) @(negedge cl);

        $display("[TB] wrap");
        applyStimulus(10'h3FA, 1'b0, 7'h7F, 32'h55555555);
        bus.req = 1'b0;
        repeat (20) @(negedge cl);

        $display("[TB] back-to-back");
        applyStimulus(10'h120, 1'b0, 7'h12, 32'h1B2D3E4F);
        applyStimulus(10'h2F8, 1'b1, 7'h33, 32'hE4E4C0C3);
        bus.req = 1'b0;
        repeat (20) @(negedge cl);

        $display("[TB] abort at cnt 5");
        w0 = writeCount;
        d0 = doneCount;
        applyStimulus(10'h080, 1'b0, 7'h21, 32'hFFFFFFFF);
        bus.x = 10'h300;
        repeat (5) @(negedge cl);
        bus.abort = 1'b1;
        @(posedge cl);
        #1;
        purgeFrom(cyc);
        readyCyc = cyc;
        @(negedge cl);
        bus.abort = 1'b0;
        bus.req   = 1'b0;
        checkOutput("abortRdy", {31'd0, bus.rdy}, 32'd1);
        repeat (20) @(negedge cl);
        checkOutput("abortWrites", 32'(writeCount - w0), 32'd5);
        checkOutput("abortDone",   32'(doneCount - d0),  32'd0);

        $display("[TB] reset at cnt 8");
        w0 = writeCount;
        d0 = doneCount;
        applyStimulus(10'h200, 1'b0, 7'h11, 32'hFFFFFFFF);
        bus.req = 1'b0;
        repeat (8) @(negedge cl);
        rst_n = 1'b0;
        @(posedge cl);
        #1;
        purgeFrom(cyc);
        @(negedge cl);
        checkOutput("midRstWe",   {31'd0, bus.we},   32'd0);
        checkOutput("midRstWad",  {22'd0, bus.wad},  32'd0);
        checkOutput("midRstWdt",  {23'd0, bus.wdt},  32'd0);
        checkOutput("midRstDone", {31'd0, bus.done}, 32'd0);
        rst_n = 1'b1;
        readyCyc = cyc;
        @(negedge cl);
        checkOutput("midRstRdy", {31'd0, bus.rdy}, 32'd1);
        repeat (20) @(negedge cl);
        checkOutput("rstWrites", 32'(writeCount - w0), 32'd8);
        checkOutput("rstDones",  32'(doneCount - d0),  32'd0);

        checkOutput("sbEmpty", 32'(sb.size()), 32'd0);
        monOn = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
